cim_array_ctrl: RTL and testbench

Sequencer for a ROWS×COLS array of XNOR/full-adder compute-in-memory bitcells. Serialises two host transaction types onto the array's shared bit-lines:
- weight writes: one row per transaction, pulsed word-line.
- binary dot-product compute: one activation vector swept across all rows, producing one signed result per row.

It sits between the host/accelerator front-end and the bitcell array, and owns WL, BL, RSEL and the WE/CE mode selects.

---
 rtl/cim_ctrl_pkg.sv | 28 ++
 rtl/cim_array_ctrl_if.sv | 35 +++
 rtl/cim_array_ctrl_timer.sv | 39 +++
 rtl/cim_array_ctrl.sv | 156 +++++++++++++++
 tb/tb_cim_array_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cim_ctrl_pkg.sv
// Shared types, mode encodings and width helpers for the compute-in-memory array sequencer.
package cim_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DRIVE = 2'd2,
      OUT   = 2'd3
   } cim_state_e;

   localparam logic WE_SHIFT  = 1'b0;
   localparam logic WE_XNOR   = 1'b1;
   localparam logic CE_INJECT = 1'b0;
   localparam logic CE_CHAIN  = 1'b1;

   function automatic int unsigned rw_f(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   function automatic int unsigned sw_f(input int unsigned cols);
      return $clog2(cols + 1);
   endfunction

   function automatic int unsigned cnt_w_f(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/cim_array_ctrl_if.sv
// Host-side bundle: weight-write request, compute request, per-row result stream and busy flag.
interface cim_array_ctrl_if
   import cim_ctrl_pkg::*;
#(
   parameter int unsigned ROWS = 8,
   parameter int unsigned COLS = 16
) ();
   localparam int unsigned RW = rw_f(ROWS);
   localparam int unsigned SW = sw_f(COLS);

   logic          W_VALID;
   logic          W_READY;
   logic [RW-1:0] W_ROW;
   logic [COLS-1:0] W_DATA;
   logic          W_ERR;
   logic          X_VALID;
   logic          X_READY;
   logic [COLS-1:0] X_DATA;
   logic          Y_VALID;
   logic          Y_READY;
   logic [RW-1:0] Y_ROW;
   logic [SW:0]   Y_DATA;
   logic          BUSY;

   modport master (
      output W_VALID, W_ROW, W_DATA, X_VALID, X_DATA, Y_READY,
      input  W_READY, W_ERR, X_READY, Y_VALID, Y_ROW, Y_DATA, BUSY
   );

   modport slave (
      input  W_VALID, W_ROW, W_DATA, X_VALID, X_DATA, Y_READY,
      output W_READY, W_ERR, X_READY, Y_VALID, Y_ROW, Y_DATA, BUSY
   );

endinterface

// File: rtl/cim_array_ctrl_timer.sv
// Loadable down-counter; done is registered and stays high once the count reaches zero.
module cim_cycle_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (load_i) begin
         cnt_d  = load_val_i;
         done_d = (load_val_i == '0);
      end else if (cnt_q != '0) begin
         cnt_d  = cnt_q - W'(1);
         done_d = (cnt_q == W'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/cim_array_ctrl.sv
// Sequences weight writes and row-by-row binary dot products onto a shared-bit-line CIM array.
module cim_array_ctrl
   import cim_ctrl_pkg::*;
#(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned COLS     = 16,
   parameter int unsigned WL_PULSE = 2,
   parameter int unsigned SETTLE   = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   cim_array_ctrl_if.slave         host,
   input  logic [sw_f(COLS)-1:0]   ARR_SUM,
   output logic [ROWS-1:0]         WL,
   output logic [ROWS-1:0]         RSEL,
   output logic [COLS-1:0]         BL,
   output logic                    WE,
   output logic                    CE
);

   localparam int unsigned RW   = rw_f(ROWS);
   localparam int unsigned SW   = sw_f(COLS);
   localparam int unsigned YW   = SW + 1;
   localparam int unsigned TMAX = ((WL_PULSE - 1) > SETTLE) ? (WL_PULSE - 1) : SETTLE;
   localparam int unsigned TW   = cnt_w_f(TMAX);

   cim_state_e      state_q;
   logic [RW-1:0]   row_q;
   logic [COLS-1:0] data_q;
   logic [ROWS-1:0] wl_q, rsel_q;
   logic [COLS-1:0] bl_q;
   logic            we_q, ce_q;
   logic            y_valid_q, w_err_q, busy_q;
   logic [YW-1:0]   y_data_q;
   logic [RW-1:0]   y_row_q;

   logic            w_row_ok_c, last_row_c, tmr_load_c, tmr_done;
   logic [RW-1:0]   row_nxt_c;
   logic [TW-1:0]   tmr_val_c;

   assign w_row_ok_c = (32'(host.W_ROW) < ROWS);
   assign last_row_c = (row_q == RW'(ROWS - 1));
   assign row_nxt_c  = row_q + RW'(1);

   // The one timer is reloaded on every entry into WRITE or DRIVE.
   assign tmr_load_c = ((state_q == IDLE) && host.W_VALID && w_row_ok_c)
                     || ((state_q == IDLE) && !host.W_VALID && host.X_VALID)
                     || ((state_q == OUT) && host.Y_READY && !last_row_c);
   assign tmr_val_c  = ((state_q == IDLE) && host.W_VALID) ? TW'(WL_PULSE - 1) : TW'(SETTLE);

   cim_cycle_timer #(.W(TW)) u_timer (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (tmr_load_c),
      .load_val_i (tmr_val_c),
      .done_o     (tmr_done)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         row_q     <= '0;
         data_q    <= '0;
         wl_q      <= '0;
         rsel_q    <= '0;
         bl_q      <= '0;
         we_q      <= WE_SHIFT;
         ce_q      <= CE_INJECT;
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_row_q   <= '0;
         w_err_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         w_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A pending write always wins over a simultaneous compute request.
               if (host.W_VALID) begin
                  if (w_row_ok_c) begin
                     state_q <= WRITE;
                     wl_q    <= ROWS'(1) << host.W_ROW;
                     bl_q    <= host.W_DATA;
                     we_q    <= WE_SHIFT;
                     ce_q    <= CE_INJECT;
                     busy_q  <= 1'b1;
                  end else begin
                     w_err_q <= 1'b1;
                  end
               end else if (host.X_VALID) begin
                  state_q <= DRIVE;
                  row_q   <= '0;
                  data_q  <= host.X_DATA;
                  rsel_q  <= ROWS'(1);
                  bl_q    <= host.X_DATA;
                  we_q    <= WE_XNOR;
                  ce_q    <= CE_CHAIN;
                  busy_q  <= 1'b1;
               end
            end
            WRITE: begin
               if (tmr_done) begin
                  state_q <= IDLE;
                  wl_q    <= '0;
                  bl_q    <= '0;
                  busy_q  <= 1'b0;
               end
            end
            DRIVE: begin
               if (tmr_done) begin
                  state_q   <= OUT;
                  y_data_q  <= YW'({ARR_SUM, 1'b0}) - YW'(COLS);
                  y_row_q   <= row_q;
                  y_valid_q <= 1'b1;
                  rsel_q    <= '0;
                  bl_q      <= '0;
                  we_q      <= WE_SHIFT;
                  ce_q      <= CE_INJECT;
               end
            end
            OUT: begin
               if (host.Y_READY) begin
                  y_valid_q <= 1'b0;
                  if (last_row_c) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DRIVE;
                     row_q   <= row_nxt_c;
                     rsel_q  <= ROWS'(1) << row_nxt_c;
                     bl_q    <= data_q;
                     we_q    <= WE_XNOR;
                     ce_q    <= CE_CHAIN;
                  end
               end
            end
         endcase
      end
   end

   // Ready is suppressed combinationally while reset is held.
   assign host.W_READY = (state_q == IDLE) && !RST;
   assign host.X_READY = (state_q == IDLE) && !RST;
   assign host.W_ERR   = w_err_q;
   assign host.Y_VALID = y_valid_q;
   assign host.Y_DATA  = y_data_q;
   assign host.Y_ROW   = y_row_q;
   assign host.BUSY    = busy_q;

   assign WL   = wl_q;
   assign RSEL = rsel_q;
   assign BL   = bl_q;
   assign WE   = we_q;
   assign CE   = ce_q;

endmodule

// File: tb/tb_cim_array_ctrl.sv
// Directed bench for cim_array_ctrl: an 8-row array plus a 5-row instance for out-of-range write rows.
module tb_cim_array_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   cim_array_ctrl_if #(.ROWS(8), .COLS(16)) hif ();
   logic [4:0]  arr_sum;
   logic [7:0]  wl, rsel;
   logic [15:0] bl;
   logic        we, ce;

   cim_array_ctrl #(.ROWS(8), .COLS(16), .WL_PULSE(2), .SETTLE(1)) dut (
      .CLK(clk), .RST(rst), .host(hif), .ARR_SUM(arr_sum),
      .WL(wl), .RSEL(rsel), .BL(bl), .WE(we), .CE(ce)
   );

   cim_array_ctrl_if #(.ROWS(5), .COLS(16)) hif2 ();
   logic [4:0]  wl2, rsel2;
   logic [15:0] bl2;
   logic        we2, ce2;

   cim_array_ctrl #(.ROWS(5), .COLS(16), .WL_PULSE(2), .SETTLE(1)) dut2 (
      .CLK(clk), .RST(rst), .host(hif2), .ARR_SUM(5'd0),
      .WL(wl2), .RSEL(rsel2), .BL(bl2), .WE(we2), .CE(ce2)
   );

   // Array model: match count of whichever row is selected.
   logic [4:0] sum_tab [8] = '{5'd16, 5'd0, 5'd8, 5'd4, 5'd12, 5'd16, 5'd1, 5'd15};
   int         y_tab   [8] = '{16, -16, 0, -8, 8, 16, -14, 14};

   always_comb begin
      arr_sum = '0;
      for (int i = 0; i < 8; i++) if (rsel[i]) arr_sum = sum_tab[i];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      hif.W_VALID = 0; hif.X_VALID = 0; hif.Y_READY = 1; hif.W_ROW = '0; hif.W_DATA = '0; hif.X_DATA = '0;
      hif2.W_VALID = 0; hif2.X_VALID = 0; hif2.Y_READY = 1; hif2.W_ROW = '0; hif2.W_DATA = '0; hif2.X_DATA = '0;
      step();
      total++;
      if ({wl, rsel, bl, we, ce} !== 34'd0) begin
         bad++; $display("FAIL reset_array got=%h exp=0", {wl, rsel, bl, we, ce});
      end
      total++;
      if ({hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, hif.W_ERR, hif.BUSY} !== 12'd0) begin
         bad++; $display("FAIL reset_host got=%h exp=0", {hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, hif.W_ERR, hif.BUSY});
      end
      total++;
      if ({hif.W_READY, hif.X_READY} !== 2'b00) begin
         bad++; $display("FAIL reset_ready got=%b exp=00", {hif.W_READY, hif.X_READY});
      end
      rst = 1'b0;
      #1;
      total++;
      if ({hif.W_READY, hif.X_READY, hif2.W_READY} !== 3'b111) begin
         bad++; $display("FAIL idle_ready got=%b exp=111", {hif.W_READY, hif.X_READY, hif2.W_READY});
      end
   endtask

   task automatic test_write();
      hif.W_VALID = 1; hif.W_ROW = 3'd3; hif.W_DATA = 16'hA5A5;
      step();
      hif.W_VALID = 0;
      for (int c = 1; c <= 2; c++) begin
         total++;
         if ({wl, bl, we, ce, hif.W_READY, hif.BUSY, hif.W_ERR} !== {8'h08, 16'hA5A5, 5'b00010}) begin
            bad++; $display("FAIL write_c%0d got=%h exp=%h", c,
                            {wl, bl, we, ce, hif.W_READY, hif.BUSY, hif.W_ERR}, {8'h08, 16'hA5A5, 5'b00010});
         end
         step();
      end
      total++;
      if ({wl, bl, hif.W_READY, hif.BUSY} !== {8'h00, 16'h0000, 2'b10}) begin
         bad++; $display("FAIL write_c3 got=%h exp=%h", {wl, bl, hif.W_READY, hif.BUSY}, {8'h00, 16'h0000, 2'b10});
      end
   endtask

   task automatic test_bad_row();
      logic [2:0] rows [3] = '{3'd7, 3'd5, 3'd4};
      for (int i = 0; i < 3; i++) begin
         hif2.W_VALID = 1; hif2.W_ROW = rows[i]; hif2.W_DATA = 16'hFFFF;
         step();
         hif2.W_VALID = 0;
         if (i < 2) begin
            total++;
            if ({hif2.W_ERR, wl2, hif2.W_READY, hif2.BUSY} !== {1'b1, 5'b00000, 2'b10}) begin
               bad++; $display("FAIL bad_row%0d_c1 got=%b exp=%b", rows[i],
                               {hif2.W_ERR, wl2, hif2.W_READY, hif2.BUSY}, {1'b1, 5'b00000, 2'b10});
            end
            step();
            total++;
            if ({hif2.W_ERR, wl2} !== 6'd0) begin
               bad++; $display("FAIL bad_row%0d_c2 got=%b exp=000000", rows[i], {hif2.W_ERR, wl2});
            end
         end else begin
            total++;
            if ({hif2.W_ERR, wl2, hif2.BUSY} !== {1'b0, 5'b10000, 1'b1}) begin
               bad++; $display("FAIL last_row_write got=%b exp=%b", {hif2.W_ERR, wl2, hif2.BUSY}, {1'b0, 5'b10000, 1'b1});
            end
            repeat (3) step();
         end
      end
   endtask

   task automatic test_sweep(input int stall_row, input int stall_n);
      int n;
      hif.Y_READY = 1; hif.X_VALID = 1; hif.X_DATA = 16'hFFFF;
      step();
      hif.X_VALID = 0;
      for (int r = 0; r < 8; r++) begin
         for (int d = 0; d < 2; d++) begin
            total++;
            if ({rsel, bl, we, ce, wl, hif.Y_VALID, hif.X_READY} !== {8'(1 << r), 16'hFFFF, 2'b11, 8'h00, 2'b00}) begin
               bad++; $display("FAIL drive_r%0d_d%0d got=%h exp=%h", r, d,
                               {rsel, bl, we, ce, wl, hif.Y_VALID, hif.X_READY}, {8'(1 << r), 16'hFFFF, 2'b11, 8'h00, 2'b00});
            end
            step();
         end
         n = (r == stall_row) ? stall_n : 0;
         hif.Y_READY = (n == 0);
         for (int k = 0; k <= n; k++) begin
            total++;
            if ({hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, rsel, bl} !== {1'b1, 6'(y_tab[r]), 3'(r), 8'h00, 16'h0000}) begin
               bad++; $display("FAIL out_r%0d_k%0d got=%h exp=%h", r, k,
                               {hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, rsel, bl}, {1'b1, 6'(y_tab[r]), 3'(r), 8'h00, 16'h0000});
            end
            if (k == n) hif.Y_READY = 1;
            step();
         end
      end
      total++;
      if ({hif.X_READY, hif.BUSY, hif.Y_VALID} !== 3'b100) begin
         bad++; $display("FAIL sweep_end got=%b exp=100", {hif.X_READY, hif.BUSY, hif.Y_VALID});
      end
   endtask

   task automatic test_priority();
      bit done = 0;
      hif.Y_READY = 1;
      hif.W_VALID = 1; hif.W_ROW = 3'd5; hif.W_DATA = 16'h1234;
      hif.X_VALID = 1; hif.X_DATA = 16'h0F0F;
      total++;
      if ({hif.W_READY, hif.X_READY} !== 2'b11) begin
         bad++; $display("FAIL prio_ready got=%b exp=11", {hif.W_READY, hif.X_READY});
      end
      step();
      hif.W_VALID = 0;
      total++;
      if ({wl, rsel, bl, hif.X_READY} !== {8'h20, 8'h00, 16'h1234, 1'b0}) begin
         bad++; $display("FAIL prio_write got=%h exp=%h", {wl, rsel, bl, hif.X_READY}, {8'h20, 8'h00, 16'h1234, 1'b0});
      end
      step();
      step();
      total++;
      if ({wl, rsel, hif.X_READY} !== {8'h00, 8'h00, 1'b1}) begin
         bad++; $display("FAIL prio_idle got=%h exp=%h", {wl, rsel, hif.X_READY}, {8'h00, 8'h00, 1'b1});
      end
      step();
      hif.X_VALID = 0;
      total++;
      if ({rsel, bl, hif.BUSY} !== {8'h01, 16'h0F0F, 1'b1}) begin
         bad++; $display("FAIL prio_compute got=%h exp=%h", {rsel, bl, hif.BUSY}, {8'h01, 16'h0F0F, 1'b1});
      end
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         done = !hif.BUSY;
      end
      total++;
      if (!done) begin
         bad++; $display("FAIL prio_drain got=busy exp=idle within 100 cycles");
      end
   endtask

   task automatic test_reset_mid();
      hif.Y_READY = 1; hif.X_VALID = 1; hif.X_DATA = 16'hAAAA;
      step();
      hif.X_VALID = 0;
      repeat (12) step();
      total++;
      if (rsel !== 8'h10) begin
         bad++; $display("FAIL mid_row4 got=%h exp=10", rsel);
      end
      rst = 1;
      #1;
      total++;
      if ({hif.W_READY, hif.X_READY} !== 2'b00) begin
         bad++; $display("FAIL mid_ready got=%b exp=00", {hif.W_READY, hif.X_READY});
      end
      step();
      rst = 0;
      total++;
      if ({wl, rsel, bl, we, ce, hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, hif.W_ERR, hif.BUSY} !== 46'd0) begin
         bad++; $display("FAIL mid_reset got=%h exp=0",
                         {wl, rsel, bl, we, ce, hif.Y_VALID, hif.Y_DATA, hif.Y_ROW, hif.W_ERR, hif.BUSY});
      end
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if ({hif.Y_VALID, rsel, hif.BUSY} !== 10'd0) begin
            bad++; $display("FAIL mid_quiet_%0d got=%h exp=0", i, {hif.Y_VALID, rsel, hif.BUSY});
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_bad_row();
      test_sweep(-1, 0);
      test_sweep(1, 5);
      test_priority();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
